// File: rtl/zigbee_tx_sequencer.sv
// Sequences one 802.15.4 PPDU (preamble, SFD, PHR, payload) from the Tx FIFO
// into the IQ modulator, one LSB-first bit per BIT_PERIOD ready-qualified cycles.
module zigbee_tx_sequencer #(
    parameter int         PREAMBLE_BYTES = 4,
    parameter logic [7:0] SFD            = 8'hA7,
    parameter int         BIT_PERIOD     = 200
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       start_i,
    input  logic [6:0] len_i,
    input  logic       abort_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       fifo_rd_o,
    input  logic       mod_ready_i,
    output logic       mod_data_o,
    output logic       mod_enable_o,
    output logic       mod_valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int              TW        = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [TW-1:0]   TIMER_MAX = TW'(BIT_PERIOD - 1);
    localparam logic [3:0]      PRE_LAST  = 4'(PREAMBLE_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_PHR,
        S_PAYLOAD
    } state_t;

    state_t        state, next_state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [3:0]    byte_cnt;
    logic [7:0]    shift_reg;
    logic [6:0]    len_q;
    logic [6:0]    bytes_left;
    logic          valid_q;
    logic          done_q;
    logic          bit_end;
    logic          byte_end;
    logic          start_frame;
    logic          frame_done;

    assign bit_end  = (state != S_IDLE) && mod_ready_i && (timer == TIMER_MAX);
    assign byte_end = bit_end && (bit_idx == 3'd7);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // PHR and PAYLOAD share the byte-boundary decision: bytes_left holds the pops still owed.
    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        frame_done  = 1'b0;
        if (state == S_IDLE) begin
            if (start_i && !abort_i) begin
                next_state  = S_PREAMBLE;
                start_frame = 1'b1;
            end
        end else if (abort_i) begin
            next_state = S_IDLE;
        end else if (byte_end) begin
            case (state)
                S_PREAMBLE: if (byte_cnt == PRE_LAST) next_state = S_SFD;
                S_SFD:      next_state = S_PHR;
                S_PHR, S_PAYLOAD: begin
                    if (bytes_left == 7'd0) begin
                        next_state = S_IDLE;
                        frame_done = 1'b1;
                    end else if (fifo_empty_i) begin
                        next_state = S_IDLE;
                    end else begin
                        next_state = S_PAYLOAD;
                    end
                end
                default:    next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o       = (state != S_IDLE);
        mod_enable_o = (state != S_IDLE);
        mod_data_o   = (state != S_IDLE) && shift_reg[0];
        fifo_rd_o    = 1'b0;
        err_o        = 1'b0;
        if (byte_end && !abort_i && (state == S_PHR || state == S_PAYLOAD) && bytes_left != 7'd0) begin
            fifo_rd_o = !fifo_empty_i;
            err_o     = fifo_empty_i;
        end
    end

    assign mod_valid_o = valid_q;
    assign done_o      = done_q;

    // Bit timer, serialiser and byte bookkeeping; valid pulses on the first cycle of every bit.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            timer      <= '0;
            bit_idx    <= 3'd0;
            byte_cnt   <= 4'd0;
            shift_reg  <= 8'h00;
            len_q      <= 7'd0;
            bytes_left <= 7'd0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= frame_done;
            if (start_frame) begin
                len_q      <= len_i;
                bytes_left <= len_i;
                shift_reg  <= 8'h00;
                timer      <= '0;
                bit_idx    <= 3'd0;
                byte_cnt   <= 4'd0;
                valid_q    <= 1'b1;
            end else if (state != S_IDLE) begin
                if (abort_i) begin
                    timer     <= '0;
                    bit_idx   <= 3'd0;
                    byte_cnt  <= 4'd0;
                    shift_reg <= 8'h00;
                end else if (bit_end) begin
                    timer   <= '0;
                    bit_idx <= bit_idx + 3'd1;
                    valid_q <= (next_state != S_IDLE);
                    if (bit_idx == 3'd7) begin
                        case (state)
                            S_PREAMBLE: begin
                                byte_cnt  <= byte_cnt + 4'd1;
                                shift_reg <= (byte_cnt == PRE_LAST) ? SFD : 8'h00;
                            end
                            S_SFD:   shift_reg <= {1'b0, len_q};
                            default: begin
                                if (fifo_rd_o) begin
                                    shift_reg  <= fifo_data_i;
                                    bytes_left <= bytes_left - 7'd1;
                                end else begin
                                    shift_reg <= 8'h00;
                                end
                            end
                        endcase
                    end else begin
                        shift_reg <= shift_reg >> 1;
                    end
                end else if (mod_ready_i) begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zigbee_tx_sequencer.sv
// Directed bench for zigbee_tx_sequencer: whole-frame vectors from a table plus
// hand-written stall, abort, reset and start-while-busy sequences.
module tb_zigbee_tx_sequencer;

    localparam int BP = 4;
    localparam int PB = 4;

    logic       clk_i = 1'b0;
    logic       resetn_i;
    logic       start_i;
    logic [6:0] len_i;
    logic       abort_i;
    logic       fifo_empty_i;
    logic [7:0] fifo_data_i;
    logic       fifo_rd_o;
    logic       mod_ready_i;
    logic       mod_data_o;
    logic       mod_enable_o;
    logic       mod_valid_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    zigbee_tx_sequencer #(
        .PREAMBLE_BYTES(PB),
        .SFD(8'hA7),
        .BIT_PERIOD(BP)
    ) dut (
        .clk_i(clk_i),
        .resetn_i(resetn_i),
        .start_i(start_i),
        .len_i(len_i),
        .abort_i(abort_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i(fifo_data_i),
        .fifo_rd_o(fifo_rd_o),
        .mod_ready_i(mod_ready_i),
        .mod_data_o(mod_data_o),
        .mod_enable_o(mod_enable_o),
        .mod_valid_o(mod_valid_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // FWFT FIFO model feeding the DUT
    logic [7:0] fifo_mem [0:3];
    int         fifo_wr = 0;
    int         fifo_ptr;
    logic       fifo_clr = 1'b0;

    always @(posedge clk_i or posedge fifo_clr) begin
        if (fifo_clr) fifo_ptr <= 0;
        else if (fifo_rd_o) fifo_ptr <= fifo_ptr + 1;
    end

    assign fifo_empty_i = (fifo_ptr >= fifo_wr);
    assign fifo_data_i  = fifo_empty_i ? 8'h00 : fifo_mem[fifo_ptr[1:0]];

    // Output monitor, sampled on the falling edge
    bit   mon_en = 1'b0;
    int   cyc, valid_n, rd_n, err_n, done_n, en_n, done_cyc, err_cyc;
    logic bits [0:255];
    int   vcyc [0:255];

    always @(negedge clk_i) begin
        if (!mon_en) begin
            cyc = 0; valid_n = 0; rd_n = 0; err_n = 0; done_n = 0; en_n = 0;
            done_cyc = 0; err_cyc = 0;
        end else begin
            if (mod_valid_o) begin
                if (valid_n < 256) begin
                    bits[valid_n] = mod_data_o;
                    vcyc[valid_n] = cyc;
                end
                valid_n++;
            end
            if (fifo_rd_o) rd_n++;
            if (mod_enable_o) en_n++;
            if (err_o) begin err_n++; err_cyc = cyc; end
            if (done_o) begin done_n++; done_cyc = cyc; end
            cyc++;
        end
    end

    int   n_cmp = 0;
    int   n_fail = 0;
    logic exp_bits [0:255];

    typedef struct {
        logic [6:0] len;
        int         fifo_n;
        logic [7:0] d0, d1, d2;
        int         exp_valid, exp_rd, exp_err, exp_done, exp_dur, exp_en;
    } vec_t;

    vec_t vecs [4];

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_fifo(input int n, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        fifo_clr = 1'b1;
        #1;
        fifo_clr = 1'b0;
        fifo_mem[0] = d0;
        fifo_mem[1] = d1;
        fifo_mem[2] = d2;
        fifo_mem[3] = 8'h00;
        fifo_wr = n;
    endtask

    task automatic push_byte(inout int idx, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            exp_bits[idx] = b[i];
            idx++;
        end
    endtask

    task automatic build_expected(input logic [6:0] len, input int nsent,
                                  input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        int idx;
        logic [7:0] pay [0:2];
        idx = 0;
        pay[0] = d0; pay[1] = d1; pay[2] = d2;
        for (int p = 0; p < PB; p++) push_byte(idx, 8'h00);
        push_byte(idx, 8'hA7);
        push_byte(idx, {1'b0, len});
        for (int p = 0; p < nsent && p < 3; p++) push_byte(idx, pay[p]);
    endtask

    task automatic apply_stimulus(input logic [6:0] len);
        start_i = 1'b1;
        len_i   = len;
        tick();
        start_i = 1'b0;
    endtask

    function automatic int stream_errors(input int first, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (first + i < 256 && bits[first + i] !== exp_bits[i]) bad++;
        end
        return bad;
    endfunction

    initial begin
        int guard;
        int nsent;
        int gaps;
        int dur;
        logic [7:0] phr;

        resetn_i    = 1'b1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        mod_ready_i = 1'b1;
        len_i       = 7'd0;
        load_fifo(0, 8'h00, 8'h00, 8'h00);
        #2 resetn_i = 1'b0;
        #3;
        check_output("reset_outs",
            int'({busy_o, mod_enable_o, mod_valid_o, mod_data_o, fifo_rd_o, done_o, err_o}), 0);
        repeat (2) @(posedge clk_i);
        #1 resetn_i = 1'b1;
        tick();

        // start and abort together in IDLE: abort wins
        start_i = 1'b1; abort_i = 1'b1; len_i = 7'd2;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        check_output("start_abort_idle_busy", int'(busy_o), 0);
        tick();

        vecs[0] = '{7'd2, 2, 8'h5A, 8'h3C, 8'h00, 64, 2, 0, 1, 256, 256};
        vecs[1] = '{7'd0, 0, 8'h00, 8'h00, 8'h00, 48, 0, 0, 1, 192, 192};
        vecs[2] = '{7'd3, 1, 8'hA5, 8'h00, 8'h00, 56, 1, 1, 0, 223, 224};
        vecs[3] = '{7'd1, 1, 8'h81, 8'h00, 8'h00, 56, 1, 0, 1, 224, 224};

        for (int v = 0; v < 4; v++) begin
            mon_en = 1'b0;
            load_fifo(vecs[v].fifo_n, vecs[v].d0, vecs[v].d1, vecs[v].d2);
            tick();
            mon_en = 1'b1;
            apply_stimulus(vecs[v].len);
            guard = 0;
            while (done_n + err_n == 0 && guard < 3000) begin
                tick();
                guard++;
            end
            repeat (4) tick();
            check_output($sformatf("v%0d_timeout", v), int'(guard >= 3000), 0);
            check_output($sformatf("v%0d_valids", v), valid_n, vecs[v].exp_valid);
            check_output($sformatf("v%0d_fifo_rd", v), rd_n, vecs[v].exp_rd);
            check_output($sformatf("v%0d_err", v), err_n, vecs[v].exp_err);
            check_output($sformatf("v%0d_done", v), done_n, vecs[v].exp_done);
            dur = (vecs[v].exp_err != 0) ? err_cyc - vcyc[0] : done_cyc - vcyc[0];
            check_output($sformatf("v%0d_duration", v), dur, vecs[v].exp_dur);
            check_output($sformatf("v%0d_enable_cycles", v), en_n, vecs[v].exp_en);
            nsent = (vecs[v].fifo_n < int'(vecs[v].len)) ? vecs[v].fifo_n : int'(vecs[v].len);
            build_expected(vecs[v].len, nsent, vecs[v].d0, vecs[v].d1, vecs[v].d2);
            check_output($sformatf("v%0d_stream", v), stream_errors(0, vecs[v].exp_valid), 0);
            gaps = 0;
            for (int i = 1; i < valid_n && i < 256; i++) if (vcyc[i] - vcyc[i-1] != BP) gaps++;
            check_output($sformatf("v%0d_bit_gaps", v), gaps, 0);
        end

        // mod_ready_i low for 10 cycles inside the first SFD bit
        mon_en = 1'b0;
        load_fifo(0, 8'h00, 8'h00, 8'h00);
        tick();
        mon_en = 1'b1;
        apply_stimulus(7'd0);
        guard = 0;
        while (done_n == 0 && guard < 3000) begin
            mod_ready_i = !(guard >= 130 && guard < 140);
            tick();
            guard++;
        end
        mod_ready_i = 1'b1;
        tick();
        check_output("stall_timeout", int'(guard >= 3000), 0);
        check_output("stall_valids", valid_n, 48);
        check_output("stall_sfd_bit_len", vcyc[33] - vcyc[32], 14);
        check_output("stall_duration", done_cyc - vcyc[0], 202);
        build_expected(7'd0, 0, 8'h00, 8'h00, 8'h00);
        check_output("stall_stream", stream_errors(0, 48), 0);

        // abort during PHR bit 3, restart one cycle after returning to IDLE
        mon_en = 1'b0;
        load_fifo(2, 8'h5A, 8'h3C, 8'h00);
        tick();
        mon_en = 1'b1;
        apply_stimulus(7'd2);
        guard = 0;
        while (done_n == 0 && guard < 3000) begin
            abort_i = (guard == 173);
            start_i = (guard == 175);
            if (guard == 174)
                check_output("abort_outs",
                    int'({busy_o, mod_enable_o, mod_valid_o, mod_data_o, fifo_rd_o, done_o, err_o}), 0);
            if (guard == 176)
                check_output("restart_first_bit", int'({busy_o, mod_enable_o, mod_valid_o, mod_data_o}), 4'b1110);
            tick();
            guard++;
        end
        abort_i = 1'b0;
        start_i = 1'b0;
        repeat (3) tick();
        check_output("abort_timeout", int'(guard >= 3000), 0);
        check_output("abort_err", err_n, 0);
        check_output("abort_done", done_n, 1);
        check_output("abort_valids", valid_n, 108);
        check_output("abort_fifo_rd", rd_n, 2);
        check_output("restart_duration", done_cyc - vcyc[44], 256);
        build_expected(7'd2, 2, 8'h5A, 8'h3C, 8'h00);
        check_output("restart_stream", stream_errors(44, 64), 0);

        // start while busy is ignored, then async reset mid-payload
        mon_en = 1'b0;
        load_fifo(2, 8'h5A, 8'h3C, 8'h00);
        tick();
        mon_en = 1'b1;
        apply_stimulus(7'd2);
        for (int k = 0; k < 200; k++) begin
            start_i = (k == 100);
            len_i   = (k == 100) ? 7'd5 : 7'd2;
            tick();
        end
        start_i = 1'b0;
        check_output("busy_mid_payload", int'(busy_o), 1);
        for (int i = 0; i < 8; i++) phr[i] = bits[40 + i];
        check_output("phr_len_kept", int'(phr), 2);
        check_output("payload_pops_before_reset", rd_n, 1);
        resetn_i = 1'b0;
        #1;
        check_output("async_reset_outs",
            int'({busy_o, mod_enable_o, mod_valid_o, mod_data_o, fifo_rd_o, done_o, err_o}), 0);
        tick();
        resetn_i = 1'b1;
        tick();
        tick();
        check_output("post_reset_outs",
            int'({busy_o, mod_enable_o, mod_valid_o, mod_data_o, fifo_rd_o, done_o, err_o}), 0);
        check_output("post_reset_no_done", done_n + err_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/zigbee_tx_sequencer.md
Name: zigbee_tx_sequencer

Overview:
Transmit-path controller that sequences one IEEE 802.15.4 PPDU from the Tx byte FIFO into the IQ modulator.
- Frame order: preamble bytes (0x00), SFD, PHR (length), then payload bytes popped from the FIFO.
- Each byte is serialised LSB-first at a programmable bit period, gated by modulator readiness.
- Sits between fifo_tx (FWFT read side) and mod_iq (data/enable inputs) in zigbee_platform, replacing direct FIFO-to-modulator wiring.

Parameters:
PREAMBLE_BYTES, 4, number of 0x00 preamble bytes (1..15)
SFD, 8'hA7, start-of-frame delimiter byte
BIT_PERIOD, 200, clk_i cycles per transmitted bit (>=2); 200 gives 250 kb/s at 50 MHz

Ports:
clk_i  in  1  system clock
resetn_i  in  1  asynchronous active-low reset
start_i  in  1  single-cycle request to send a frame; sampled only in IDLE
len_i  in  7  payload length in bytes (0..127); captured with start_i
abort_i  in  1  cancels frame in progress
fifo_empty_i  in  1  Tx FIFO empty flag
fifo_data_i  in  8  Tx FIFO head byte (first-word fall-through)
fifo_rd_o  out  1  one-cycle pop strobe
mod_ready_i  in  1  modulator/DAC ready; bit timer runs only while high
mod_data_o  out  1  current bit to modulator
mod_enable_o  out  1  high for the whole frame
mod_valid_o  out  1  one-cycle pulse on first cycle of each bit
busy_o  out  1  high while state != IDLE
done_o  out  1  one-cycle pulse on normal frame completion
err_o  out  1  one-cycle pulse on FIFO underrun

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, counters 0, captured length 0.
- States: IDLE -> PREAMBLE -> SFD -> PHR -> PAYLOAD -> IDLE. With len=0, PHR -> IDLE.
- IDLE: on start_i=1 at an edge, capture len_i, load shift reg 0x00, and enter PREAMBLE next cycle.
- Frame-start cycle (first cycle in PREAMBLE): busy_o=1, mod_enable_o=1, mod_valid_o=1, mod_data_o=bit0.
- Bit timing:
  - Timer counts 0..BIT_PERIOD-1, advancing only when mod_ready_i=1; it freezes when low.
  - The bit advances on the cycle after timer=BIT_PERIOD-1 with mod_ready_i=1; mod_valid_o pulses that cycle.
  - Shift reg shifts right; bit index counts 0..7.
- Byte boundary (bit 7 completing):
  - PREAMBLE: byte counter increments; after PREAMBLE_BYTES bytes, load SFD and go to SFD.
  - SFD: load {1'b0, len} and go to PHR.
  - PHR: if len=0, frame ends; otherwise check the FIFO.
  - PAYLOAD: if bytes remain, check the FIFO; otherwise frame ends.
- FIFO check:
  - If fifo_empty_i=0: assert fifo_rd_o for that single cycle, load fifo_data_i, and enter/stay in PAYLOAD.
  - If fifo_empty_i=1: underrun. err_o pulses, mod_enable_o/busy_o drop, next state IDLE, no fifo_rd_o, no done_o.
- FIFO pops: exactly len per frame, one per byte boundary; never in IDLE.
- Frame end: the cycle after the last bit's final timer cycle, done_o=1 for one cycle, state IDLE, mod_enable_o=0, busy_o=0, mod_data_o=0.
- Ideal duration (mod_ready_i stuck high): (PREAMBLE_BYTES+2+len)*8*BIT_PERIOD cycles, from first mod_valid_o to done_o.
- start_i while busy: ignored; len_i not recaptured.
- abort_i=1 in any non-IDLE state: next cycle IDLE, all outputs 0, no done_o/err_o/fifo_rd_o that cycle.
- abort_i has priority over byte-boundary events in the same cycle.
- abort_i in IDLE: no effect. start_i and abort_i together in IDLE: abort wins, no frame.
- Back-to-back: start_i is accepted on the cycle done_o is high (state already IDLE), so the next frame starts the following cycle.

Test Plan:
1. BIT_PERIOD=4, PREAMBLE_BYTES=4, len=2, FIFO {0x5A,0x3C}, ready high -> serial stream is 32 zero bits, A7 LSB-first (1,1,1,0,0,1,0,1), 0x02, 0x5A, 0x3C.
   Expect 64 mod_valid_o pulses 4 cycles apart, 2 fifo_rd_o pulses, done_o at cycle 256 after the first valid.
2. len=0, FIFO empty -> 48 bits (preamble, A7, 0x00), no fifo_rd_o, no err_o, done_o after 192 cycles.
3. len=3, FIFO holds 1 byte -> first payload byte sent, then err_o pulses at the second-payload boundary.
   Expect 1 fifo_rd_o, mod_enable_o low next cycle, no done_o.
4. mod_ready_i low for 10 cycles mid-SFD -> bit held for 14 cycles instead of 4, stream content unchanged, done_o delayed by 10 cycles.
5. abort_i in PHR bit 3 -> IDLE next cycle, outputs 0, no done_o/err_o.
   start_i 1 cycle later -> frame restarts with preamble bit 0.
6. resetn_i low mid-payload -> outputs 0 asynchronously; after release, IDLE, busy_o=0; start_i during a frame ignored (verify len unchanged).
